lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
//  Parametrised load/store unit for the MEM stage of the pipelined core. It replaces the
//  fixed 32-bit combinational byte-enable logic with a request/response FSM that
//  waits for dmem_resp and stalls the pipeline while it waits. It adds store-data lane
//  shifting, load sign/zero extension and a misalignment/illegal-funct3 fault.
//  Inputs come from the EX/MEM register. Outputs go to D-Mem, the hazard unit (stall) and the MEM/WB register.
// PARAMETERS
//  XLEN    32  data width; 32 or 64. LANES = XLEN/8; OFS_W = log2(LANES)
//  ADDR_W  32  address width
// PORTS
//  clk               in   1         clock
//  rst               in   1         asynchronous, active-high reset
//  req_valid         in   1         MEM stage holds a memory op this cycle
//  req_load          in   1         op is a load (mutually exclusive with req_store)
//  req_store         in   1         op is a store
//  funct3            in   3         RISC-V load/store funct3
//  addr              in   ADDR_W    effective byte address (alu_out_MEM)
//  wdata             in   XLEN      store data, unshifted (rs2_out_MEM)
//  dmem_read         out  1         registered read strobe
//  dmem_write        out  1         registered write strobe
//  dmem_address      out  ADDR_W    registered, aligned down to LANES bytes
//  dmem_byte_enable  out  LANES     registered lane mask
//  dmem_wdata        out  XLEN      registered, shifted store data
//  dmem_resp         in   1         memory completion, one cycle
//  dmem_rdata        in   XLEN      read data, valid with dmem_resp
//  stall             out  1         freeze IF..MEM registers
//  done              out  1         op completes this cycle
//  load_data         out  XLEN      extended load result, valid while done & load
//  fault             out  1         one-cycle pulse: misaligned or illegal funct3
// BEHAVIOUR
//  - Reset: state IDLE; every registered output and latched field is 0. An in-flight access is abandoned.
//    A dmem_resp arriving after reset, or any dmem_resp in IDLE, is ignored.
//  - start = req_valid & (req_load|req_store) in IDLE.
//    bad = illegal funct3 for XLEN, or addr not aligned to access size.
//  - Sizes: b=1, h=2, w=4, d=8 bytes. In XLEN=32, ld/sd/lwu are illegal. Any store funct3 above sd/sw is illegal.
//  - IDLE, start & bad: fault=1 for 1 cycle, stall=0, no memory strobe, stay IDLE.
//  - IDLE, start & !bad: stall=1. Latch op, funct3, offset=addr[OFS_W-1:0].
//    On next edge go to ACCESS. dmem_read or dmem_write rises on the same edge.
//    byte_enable = ((1<<size)-1) << offset. wdata is shifted left by 8*offset.
//  - ACCESS: strobes/address/be/wdata held stable. stall = !dmem_resp.
//    When dmem_resp=1: done=1, stall=0, strobes clear on the next edge, go to IDLE.
//    The pipeline advances on this same edge.
//  - load_data (combinational, in the dmem_resp cycle): field = dmem_rdata >> 8*offset.
//    lb/lh/lw sign-extend to XLEN. lbu/lhu/lwu zero-extend. ld passes through.
//    load_data is 0 when done=0 or the op is a store.
//  - Minimum latency is 2 cycles (accept + resp). N wait cycles add N cycles of stall.
//  - Only one op is outstanding at a time. req_* is ignored in ACCESS; the held pipeline re-presents the same op.
//    After done, the next op can be accepted in the following cycle.
//  - fault and done are never both 1. done is asserted for exactly 1 cycle per accepted op.
// STRUCTURE
//  - rv32i_types package: load_funct3_t (lb,lh,lw,ld,lbu,lhu,lwu) and store_funct3_t (sb,sh,sw,sd).
//    Add lsu_state_t {IDLE, ACCESS} to it.
//  - Sub-module lsu_align, combinational, parametrised by XLEN. Computes size/legality, the byte-enable mask,
//    the store shift and the load shift+extend. The FSM and output registers stay in the top module.
// TESTING
//  1 XLEN=32, sb addr=0x1003 wdata=0xAB, resp on 1st ACCESS cycle -> be=4'h8, dmem_wdata=0xAB000000,
//    dmem_address=0x1000, stall high 1 cycle, done 1 cycle.
//  2 lh addr=0x2002, dmem_rdata=0x8001_1234 -> load_data=0xFFFF8001. Same with lhu -> 0x00008001.
//    lb addr=0x2001 -> 0x00000012.
//  3 sw addr=0x1002 and funct3=3'b011 on XLEN=32 -> fault pulse, dmem_read=dmem_write=0, stall=0, done=0.
//  4 lw with resp delayed 3 ACCESS cycles -> stall high 4 consecutive cycles.
//    Strobes/address stable throughout. done on the resp cycle only.
//  5 rst asserted mid-ACCESS, then a stray dmem_resp -> all outputs 0 at once, IDLE, no done.
//    The next sw completes normally.
//  6 XLEN=64, sd addr=0x10 -> be=8'hFF. lw addr=0x14, rdata=0xF000_0000_xxxx_xxxx -> 0xFFFFFFFF_F0000000.
//    sd addr=0x14 -> fault.

Source files
------------

// File: rtl/lsu_mem_stage_pkg.sv
// rv32i_types: load/store funct3 encodings and LSU FSM states
package rv32i_types;
  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    ld  = 3'b011,
    lbu = 3'b100,
    lhu = 3'b101,
    lwu = 3'b110
  } load_funct3_t;
  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010,
    sd = 3'b011
  } store_funct3_t;
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } lsu_state_t;
endpackage

// File: rtl/lsu_mem_stage_align.sv
// lsu_align: access legality, lane mask, store shift and load shift/extend
module lsu_align
  import rv32i_types::*;
#(
  parameter int XLEN = 32,
  localparam int LANES = XLEN / 8,
  localparam int OFS_W = $clog2(LANES)
) (
  input  logic             is_load,
  input  logic [2:0]       funct3,
  input  logic [OFS_W-1:0] ofs,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic             bad,
  output logic [LANES-1:0] be,
  output logic [XLEN-1:0]  wdata_sh,
  output logic [XLEN-1:0]  load_data
);
  logic [3:0] nb;
  logic [LANES:0] mask;
  logic [6:0] sh;
  logic [XLEN-1:0] fld, zx;
  logic signed [XLEN-1:0] sx;
  logic legal, aligned;
  // size decode, legality, lane placement, and extension via left-then-right shift by (XLEN - access bits)
  always_comb begin
    nb = 4'd1 << funct3[1:0];
    legal = is_load ? (funct3 != 3'b111 && (XLEN == 64 || (funct3 != ld && funct3 != lwu)))
                    : (funct3 <= sd && (XLEN == 64 || funct3 != sd));
    aligned = (ofs & OFS_W'(nb - 4'd1)) == '0;
    bad = !legal || !aligned;
    mask = ((LANES + 1)'(1) << nb) - (LANES + 1)'(1);
    be = mask[LANES-1:0] << ofs;
    wdata_sh = wdata << {ofs, 3'b000};
    fld = rdata >> {ofs, 3'b000};
    sh = 7'(XLEN) - {nb, 3'b000};
    zx = (fld << sh) >> sh;
    sx = $signed(fld << sh) >>> sh;
    load_data = funct3[2] ? zx : XLEN'(sx);
  end
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit with request/response handshake and pipeline stall
module lsu_mem_stage
  import rv32i_types::*;
#(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  localparam int LANES = XLEN / 8,
  localparam int OFS_W = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [LANES-1:0]  dmem_byte_enable,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_resp,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              stall,
  output logic              done,
  output logic [XLEN-1:0]   load_data,
  output logic              fault
);
  lsu_state_t state_q, state_d;
  logic ld_q;
  logic [2:0] f3_q;
  logic [OFS_W-1:0] ofs_q;
  logic idle, start, accept, bad;
  logic [LANES-1:0] be;
  logic [XLEN-1:0] wsh, ldata;
  assign idle = state_q == IDLE;
  assign start = idle && req_valid && (req_load || req_store);
  assign accept = start && !bad;
  lsu_align #(.XLEN(XLEN)) u_align (
    .is_load   (idle ? req_load : ld_q),
    .funct3    (idle ? funct3 : f3_q),
    .ofs       (idle ? addr[OFS_W-1:0] : ofs_q),
    .wdata     (wdata),
    .rdata     (dmem_rdata),
    .bad       (bad),
    .be        (be),
    .wdata_sh  (wsh),
    .load_data (ldata)
  );
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // accept a legal op from IDLE, return once memory responds
  always_comb state_d = idle ? (accept ? ACCESS : IDLE) : (dmem_resp ? IDLE : ACCESS);
  // handshake outputs; the align unit sees the latched op while in ACCESS
  always_comb begin
    fault = start && bad;
    done = !idle && dmem_resp;
    stall = accept || (!idle && !dmem_resp);
    load_data = (done && ld_q) ? ldata : '0;
  end
  // memory request register: loaded on accept, strobes dropped after the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_q <= 1'b0;
      f3_q <= '0;
      ofs_q <= '0;
      dmem_read <= 1'b0;
      dmem_write <= 1'b0;
      dmem_address <= '0;
      dmem_byte_enable <= '0;
      dmem_wdata <= '0;
    end else if (accept) begin
      ld_q <= req_load;
      f3_q <= funct3;
      ofs_q <= addr[OFS_W-1:0];
      dmem_read <= req_load;
      dmem_write <= req_store;
      dmem_address <= {addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
      dmem_byte_enable <= be;
      dmem_wdata <= wsh;
    end else if (done) begin
      dmem_read <= 1'b0;
      dmem_write <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed and randomized checks of lsu_mem_stage at XLEN 32 and 64
module tb_lsu_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic sel64 = 1'b0;
  logic req_valid = 1'b0, req_load = 1'b0, req_store = 1'b0, dmem_resp = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0, rdata = '0;
  logic r32, w32, st32, dn32, f32, r64, w64, st64, dn64, f64;
  logic [31:0] a32, a64, wd32, ld32;
  logic [3:0] be32;
  logic [7:0] be64;
  logic [63:0] wd64, ld64;
  logic o_rd, o_wr, o_st, o_dn, o_f;
  logic [31:0] o_a;
  logic [7:0] o_be;
  logic [63:0] o_wd, o_ld;
  int total = 0;
  int bad = 0;

  lsu_mem_stage #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel64), .req_load(req_load),
    .req_store(req_store), .funct3(funct3), .addr(addr), .wdata(wdata[31:0]),
    .dmem_read(r32), .dmem_write(w32), .dmem_address(a32), .dmem_byte_enable(be32),
    .dmem_wdata(wd32), .dmem_resp(dmem_resp && !sel64), .dmem_rdata(rdata[31:0]),
    .stall(st32), .done(dn32), .load_data(ld32), .fault(f32)
  );
  lsu_mem_stage #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel64), .req_load(req_load),
    .req_store(req_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .dmem_read(r64), .dmem_write(w64), .dmem_address(a64), .dmem_byte_enable(be64),
    .dmem_wdata(wd64), .dmem_resp(dmem_resp && sel64), .dmem_rdata(rdata),
    .stall(st64), .done(dn64), .load_data(ld64), .fault(f64)
  );

  always_comb begin
    o_rd = sel64 ? r64 : r32;
    o_wr = sel64 ? w64 : w32;
    o_st = sel64 ? st64 : st32;
    o_dn = sel64 ? dn64 : dn32;
    o_f = sel64 ? f64 : f32;
    o_a = sel64 ? a64 : a32;
    o_be = sel64 ? be64 : {4'b0, be32};
    o_wd = sel64 ? wd64 : {32'b0, wd32};
    o_ld = sel64 ? ld64 : {32'b0, ld32};
  end

  task automatic op(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                    input logic [63:0] wd, input logic [63:0] rd, input int waits,
                    output int flts, output int stalls, output int dones,
                    output bit srd, output bit swr, output logic [31:0] sa,
                    output logic [7:0] sbe, output logic [63:0] swd, output logic [63:0] sld,
                    output bit stable, output bit cleared);
    @(negedge clk);
    req_valid = 1'b1; req_load = ld; req_store = !ld; funct3 = f3; addr = a;
    wdata = wd; rdata = rd; dmem_resp = 1'b0;
    #1;
    flts = int'(o_f); stalls = int'(o_st); dones = int'(o_dn); sld = '0; stable = 1'b1;
    @(negedge clk);
    if (flts != 0) req_valid = 1'b0;
    #1;
    srd = o_rd; swr = o_wr; sa = o_a; sbe = o_be; swd = o_wd;
    if (flts != 0) flts += int'(o_f);
    else
      for (int k = 0; k <= waits; k++) begin
        dmem_resp = (k == waits);
        #1;
        stalls += int'(o_st);
        dones += int'(o_dn);
        flts += int'(o_f);
        if (o_dn) sld = o_ld;
        if (o_rd !== srd || o_wr !== swr || o_a !== sa || o_be !== sbe || o_wd !== swd) stable = 1'b0;
        @(negedge clk);
      end
    req_valid = 1'b0; dmem_resp = 1'b0;
    #1;
    dones += int'(o_dn); stalls += int'(o_st);
    cleared = !o_rd && !o_wr;
  endtask

  task automatic model(input bit is64, input bit ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] rd, output bit e_bad,
                       output logic [7:0] e_be, output logic [31:0] e_a,
                       output logic [63:0] e_wd, output logic [63:0] e_ld);
    int lanes, size, ofs;
    bit legal;
    logic [63:0] keep, rdm;
    lanes = is64 ? 8 : 4;
    size = 1 << f3[1:0];
    ofs = int'(a % lanes);
    keep = is64 ? '1 : 64'hFFFF_FFFF;
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} || (is64 && f3 inside {3'd3, 3'd6}))
               : (f3 <= 3'd2 || (is64 && f3 == 3'd3));
    e_bad = !legal || (a % size != 0);
    e_be = '0;
    for (int i = 0; i < size; i++) if (ofs + i < lanes) e_be[ofs+i] = 1'b1;
    e_a = a - ofs;
    e_wd = (wd << (8 * ofs)) & keep;
    rdm = rd & keep;
    e_ld = '0;
    for (int i = 0; i < size; i++) e_ld |= ((rdm >> (8 * (ofs + i))) & 64'hFF) << (8 * i);
    if (!f3[2] && size < 8 && e_ld[8*size-1]) e_ld |= '1 << (8 * size);
    e_ld = ld ? (e_ld & keep) : '0;
  endtask

  int flts, stalls, dones;
  bit srd, swr, stable, cleared;
  logic [31:0] sa;
  logic [7:0] sbe;
  logic [63:0] swd, sld;

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel64 = s[0];
      #1;
      total++; if ({o_rd, o_wr, o_st, o_dn, o_f} !== 5'b0) begin bad++; $display("FAIL reset_ctl sel64=%0d got=%b exp=00000", s, {o_rd, o_wr, o_st, o_dn, o_f}); end
      total++; if ({o_a, o_be, o_wd, o_ld} !== '0) begin bad++; $display("FAIL reset_data sel64=%0d addr=%h be=%h wd=%h ld=%h exp=0", s, o_a, o_be, o_wd, o_ld); end
    end
    sel64 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_byte();
    sel64 = 1'b0;
    op(1'b0, 3'b000, 32'h1003, 64'hAB, 64'h0, 0, flts, stalls, dones, srd, swr, sa, sbe, swd, sld, stable, cleared);
    total++; if (sbe !== 8'h08) begin bad++; $display("FAIL sb_be got=%h exp=08", sbe); end
    total++; if (swd !== 64'hAB00_0000) begin bad++; $display("FAIL sb_wdata got=%h exp=ab000000", swd); end
    total++; if (sa !== 32'h1000) begin bad++; $display("FAIL sb_addr got=%h exp=00001000", sa); end
    total++; if ({srd, swr} !== 2'b01) begin bad++; $display("FAIL sb_strobes got=%b exp=01", {srd, swr}); end
    total++; if (stalls != 1 || dones != 1 || flts != 0) begin bad++; $display("FAIL sb_handshake stall=%0d done=%0d fault=%0d exp=1/1/0", stalls, dones, flts); end
    total++; if (sld !== '0 || !cleared) begin bad++; $display("FAIL sb_tail ld=%h cleared=%0d exp=0/1", sld, cleared); end
  endtask

  task automatic test_load_ext();
    logic [2:0] f3s[3] = '{3'b001, 3'b101, 3'b000};
    logic [31:0] as[3] = '{32'h2002, 32'h2002, 32'h2001};
    logic [63:0] exps[3] = '{64'hFFFF_8001, 64'h0000_8001, 64'h12};
    sel64 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      op(1'b1, f3s[i], as[i], 64'h0, 64'h8001_1234, 0, flts, stalls, dones, srd, swr, sa, sbe, swd, sld, stable, cleared);
      total++; if (sld !== exps[i]) begin bad++; $display("FAIL load_ext%0d got=%h exp=%h", i, sld, exps[i]); end
      total++; if ({srd, swr} !== 2'b10 || dones != 1) begin bad++; $display("FAIL load_hs%0d strobes=%b done=%0d exp=10/1", i, {srd, swr}, dones); end
    end
  endtask

  task automatic test_fault();
    logic [2:0] f3s[3] = '{3'b010, 3'b011, 3'b011};
    logic [31:0] as[3] = '{32'h1002, 32'h1000, 32'h1000};
    bit lds[3] = '{1'b0, 1'b0, 1'b1};
    sel64 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      op(lds[i], f3s[i], as[i], 64'h55, 64'h0, 0, flts, stalls, dones, srd, swr, sa, sbe, swd, sld, stable, cleared);
      total++; if (flts != 1) begin bad++; $display("FAIL fault_pulse%0d got=%0d exp=1", i, flts); end
      total++; if ({srd, swr} !== 2'b00 || stalls != 0 || dones != 0) begin bad++; $display("FAIL fault_quiet%0d strobes=%b stall=%0d done=%0d exp=00/0/0", i, {srd, swr}, stalls, dones); end
    end
  endtask

  task automatic test_wait_states();
    sel64 = 1'b0;
    op(1'b1, 3'b010, 32'h3004, 64'h0, 64'hCAFE_F00D, 3, flts, stalls, dones, srd, swr, sa, sbe, swd, sld, stable, cleared);
    total++; if (stalls != 4) begin bad++; $display("FAIL wait_stall got=%0d exp=4", stalls); end
    total++; if (dones != 1 || !stable) begin bad++; $display("FAIL wait_done done=%0d stable=%0d exp=1/1", dones, stable); end
    total++; if (sld !== 64'hCAFE_F00D || sa !== 32'h3004 || sbe !== 8'h0F) begin bad++; $display("FAIL wait_data ld=%h addr=%h be=%h exp=cafef00d/3004/0f", sld, sa, sbe); end
  endtask

  task automatic test_reset_mid();
    sel64 = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; funct3 = 3'b010; addr = 32'h3008;
    @(negedge clk);
    #2;
    total++; if (o_rd !== 1'b1 || o_st !== 1'b1) begin bad++; $display("FAIL mid_access rd=%b stall=%b exp=1/1", o_rd, o_st); end
    rst = 1'b1; req_valid = 1'b0;
    #1;
    total++; if ({o_rd, o_wr, o_st, o_dn, o_f} !== 5'b0 || {o_a, o_be, o_wd} !== '0) begin bad++; $display("FAIL mid_reset ctl=%b addr=%h be=%h wd=%h exp=0", {o_rd, o_wr, o_st, o_dn, o_f}, o_a, o_be, o_wd); end
    @(negedge clk);
    rst = 1'b0; dmem_resp = 1'b1;
    #1;
    total++; if (o_dn !== 1'b0 || o_st !== 1'b0 || o_ld !== '0) begin bad++; $display("FAIL stray_resp done=%b stall=%b ld=%h exp=0/0/0", o_dn, o_st, o_ld); end
    @(negedge clk);
    dmem_resp = 1'b0;
    op(1'b0, 3'b010, 32'h0040, 64'h1234_5678, 64'h0, 1, flts, stalls, dones, srd, swr, sa, sbe, swd, sld, stable, cleared);
    total++; if (dones != 1 || stalls != 2 || sbe !== 8'h0F || swd !== 64'h1234_5678) begin bad++; $display("FAIL post_reset_sw done=%0d stall=%0d be=%h wd=%h exp=1/2/0f/12345678", dones, stalls, sbe, swd); end
  endtask

  task automatic test_xlen64();
    sel64 = 1'b1;
    op(1'b0, 3'b011, 32'h10, 64'h1122_3344_5566_7788, 64'h0, 0, flts, stalls, dones, srd, swr, sa, sbe, swd, sld, stable, cleared);
    total++; if (sbe !== 8'hFF || swd !== 64'h1122_3344_5566_7788 || dones != 1) begin bad++; $display("FAIL sd64 be=%h wd=%h done=%0d exp=ff/1122334455667788/1", sbe, swd, dones); end
    op(1'b1, 3'b010, 32'h14, 64'h0, 64'hF000_0000_1234_5678, 0, flts, stalls, dones, srd, swr, sa, sbe, swd, sld, stable, cleared);
    total++; if (sld !== 64'hFFFF_FFFF_F000_0000 || sbe !== 8'hF0 || sa !== 32'h10) begin bad++; $display("FAIL lw64 ld=%h be=%h addr=%h exp=fffffffff0000000/f0/10", sld, sbe, sa); end
    op(1'b0, 3'b011, 32'h14, 64'h1, 64'h0, 0, flts, stalls, dones, srd, swr, sa, sbe, swd, sld, stable, cleared);
    total++; if (flts != 1 || dones != 0 || stalls != 0) begin bad++; $display("FAIL sd64_misaligned fault=%0d done=%0d stall=%0d exp=1/0/0", flts, dones, stalls); end
    op(1'b1, 3'b110, 32'h14, 64'h0, 64'hF000_0000_1234_5678, 2, flts, stalls, dones, srd, swr, sa, sbe, swd, sld, stable, cleared);
    total++; if (sld !== 64'h0000_0000_F000_0000 || stalls != 3) begin bad++; $display("FAIL lwu64 ld=%h stall=%0d exp=00000000f0000000/3", sld, stalls); end
    sel64 = 1'b0;
  endtask

  task automatic test_random();
    bit ld, e_bad;
    logic [2:0] f3;
    logic [31:0] a, e_a;
    logic [63:0] wd, rd, e_wd, e_ld;
    logic [7:0] e_be;
    int waits;
    for (int n = 0; n < 300; n++) begin
      sel64 = 1'($urandom_range(0, 1));
      ld = 1'($urandom_range(0, 1));
      f3 = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a &= ~((32'd1 << f3[1:0]) - 32'd1);
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      waits = $urandom_range(0, 3);
      model(sel64, ld, f3, a, wd, rd, e_bad, e_be, e_a, e_wd, e_ld);
      op(ld, f3, a, wd, rd, waits, flts, stalls, dones, srd, swr, sa, sbe, swd, sld, stable, cleared);
      total++; if (flts != int'(e_bad)) begin bad++; $display("FAIL rnd%0d_fault x64=%0d ld=%0d f3=%0d a=%h got=%0d exp=%0d", n, sel64, ld, f3, a, flts, e_bad); end
      if (e_bad) begin
        total++; if (dones != 0 || stalls != 0 || {srd, swr} !== 2'b00) begin bad++; $display("FAIL rnd%0d_badop done=%0d stall=%0d strobes=%b exp=0/0/00", n, dones, stalls, {srd, swr}); end
      end else begin
        total++; if (dones != 1 || stalls != waits + 1 || !stable || !cleared) begin bad++; $display("FAIL rnd%0d_hs done=%0d stall=%0d stable=%0d cleared=%0d exp=1/%0d/1/1", n, dones, stalls, stable, cleared, waits + 1); end
        total++; if ({srd, swr} !== {ld, !ld} || sa !== e_a || sbe !== e_be) begin bad++; $display("FAIL rnd%0d_req strobes=%b addr=%h be=%h exp=%b/%h/%h", n, {srd, swr}, sa, sbe, {ld, !ld}, e_a, e_be); end
        total++; if (!ld && swd !== e_wd) begin bad++; $display("FAIL rnd%0d_wdata got=%h exp=%h", n, swd, e_wd); end
        total++; if (sld !== e_ld) begin bad++; $display("FAIL rnd%0d_ldata f3=%0d a=%h rd=%h got=%h exp=%h", n, f3, a, rd, sld, e_ld); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_ext();
    test_fault();
    test_wait_states();
    test_reset_mid();
    test_xlen64();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
